gol_run_controller: RTL and testbench
=====================================

# gol_run_controller

Sequencing controller for the Game of Life engine. It turns debounced push-button levels into edit, run, pause and single-step commands. It owns the board row-write port while editing, and paces the generation engine with a programmable tick through a start/done handshake. It accumulates generation and birth statistics for the display path.

## Interface
- TICK_DIV, 50_000_000: ClkPort cycles between generation launches in RUN; minimum 2.
- ROWS, 16: board rows; row index width is 4 bits.
- ClkPort  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_run_i  in  1  run/pause toggle, level; synchronised and debounced upstream.
- btn_step_i  in  1  single-generation request, level.
- btn_load_i  in  1  write row_data_i into the selected row, level.
- btn_up_i / btn_down_i  in  1 each  move the edit row, level.
- btn_edit_i  in  1  return from PAUSE to EDIT, level.
- row_data_i  in  16  switch pattern for the selected row.
- eng_busy_i  in  1  engine is computing a generation.
- eng_done_i  in  1  single-cycle pulse: generation committed.
- eng_births_i  in  9  births in that generation (0..256); valid with eng_done_i.
- eng_start_o  out  1  single-cycle generation launch pulse.
- row_we_o  out  1  single-cycle board row write strobe.
- row_sel_o  out  4  row written; always equals edit_row_o.
- row_wdata_o  out  16  data written.
- edit_row_o  out  4  current edit row.
- state_o  out  2  EDIT=0, RUN=1, PAUSE=2, STEP=3.
- generation_cnt_o  out  32  generations completed since reset.
- birth_cnt_o  out  32  cumulative births since reset.

## Operation
- Buttons act only on a rising edge: the current sample is 1 and the registered previous sample is 0. Previous-sample registers reset to 1, so a button held through reset does nothing.
- EDIT
  - Up edge decrements edit_row if it is above 0. Down edge increments it if it is below ROWS-1. Up and down in the same cycle: no move.
  - Load edge pulses row_we_o with row_wdata_o = row_data_i.
  - Run edge goes to RUN: tick counter cleared, edit_row cleared to 0.
  - Step edge, when eng_busy_i = 0, pulses eng_start_o and goes to STEP with return = PAUSE.
  - Priority when several edges coincide: run > step > load > up/down. Lower-priority edges in that cycle are dropped.
- RUN
  - The tick counter counts 0..TICK_DIV-1.
  - At TICK_DIV-1 with eng_busy_i = 0: pulse eng_start_o, clear the counter, go to STEP with return = RUN.
  - At TICK_DIV-1 with eng_busy_i = 1: hold the counter at terminal count until busy drops.
  - Run edge goes to PAUSE; the counter holds. Run beats a same-cycle tick launch.
- PAUSE
  - Run edge goes to RUN and clears the counter.
  - Step edge, when eng_busy_i = 0, launches as in EDIT with return = PAUSE.
  - Edit edge goes to EDIT.
  - Priority: run > step > edit.
- STEP
  - Waits for eng_done_i, then goes to the return state.
  - A run edge while in STEP with return = RUN changes the return state to PAUSE. All other edges are ignored.
- Statistics update on eng_done_i in STEP:
  - generation_cnt_o increments by 1, saturating at 32'hFFFF_FFFF.
  - birth_cnt_o adds zero-extended eng_births_i, saturating at 32'hFFFF_FFFF.
- eng_done_i outside STEP is ignored: no counter update, no state change.
- row_we_o is never asserted outside EDIT. The engine owns the board in all other states; load edges there are discarded.
- eng_start_o is never asserted while eng_busy_i = 1. A step edge while busy is dropped, not queued.

## Timing
- Reset values: state_o = EDIT, tick counter 0, all outputs 0, return state PAUSE.
- Reset acts asynchronously and may arrive mid-STEP. The controller returns to EDIT with counters cleared; a later eng_done_i is ignored.
- Edge-to-action latency: an input sampled high at clock edge k, with the previous sample low, changes registered outputs at edge k.
  - row_we_o and eng_start_o are high for exactly the following cycle.
- RUN launch cadence: the first eng_start_o comes TICK_DIV cycles after entry to RUN. Later launches come TICK_DIV cycles after each return to RUN, plus engine time.
- Done-to-state: eng_done_i sampled at edge k means state_o and the counters are updated at edge k.

## Test plan
- Reset held with btn_run_i = 1, then released → state_o = 0 and no transition until btn_run_i falls and rises again.
- EDIT: down ×3, load with row_data_i = 16'hA5A5 → one-cycle row_we_o, row_sel_o = 3, row_wdata_o = 16'hA5A5. Up ×5 → edit_row_o = 0.
- TICK_DIV = 4, engine model with 2-cycle busy and done with births = 5 → eng_start_o every 7 cycles. After 3 generations: generation_cnt_o = 3, birth_cnt_o = 15.
- Run edge during STEP → state_o = PAUSE after done. A step edge then gives exactly one more generation and generation_cnt_o increments by 1.
- Tick expiry with eng_busy_i forced high for 10 cycles → no start pulse; start comes the cycle after busy drops. A spurious eng_done_i in PAUSE leaves the counters unchanged.
- Preload generation_cnt_o and birth_cnt_o to 32'hFFFF_FFFE by force, then done with births = 9 → both saturate at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/gol_run_controller_if.sv
// Engine handshake and board row-write port of the Game of Life run controller.
// The master side is the controller; the slave side is the engine and board.
interface gol_run_controller_if;
    logic        eng_start_o;
    logic        eng_busy_i;
    logic        eng_done_i;
    logic [8:0]  eng_births_i;
    logic        row_we_o;
    logic [3:0]  row_sel_o;
    logic [15:0] row_wdata_o;

    modport master (
        output eng_start_o,
        output row_we_o,
        output row_sel_o,
        output row_wdata_o,
        input  eng_busy_i,
        input  eng_done_i,
        input  eng_births_i
    );

    modport slave (
        input  eng_start_o,
        input  row_we_o,
        input  row_sel_o,
        input  row_wdata_o,
        output eng_busy_i,
        output eng_done_i,
        output eng_births_i
    );
endinterface

// File: rtl/gol_run_controller.sv
// Game of Life run controller: turns button edges into edit / run / pause /
// single-step commands, owns the board row-write port while editing, paces the
// engine with a programmable tick and accumulates generation/birth statistics.
module gol_run_controller #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned ROWS     = 16
) (
    input  logic                        ClkPort,
    input  logic                        reset,
    input  logic                        btn_run_i,
    input  logic                        btn_step_i,
    input  logic                        btn_load_i,
    input  logic                        btn_up_i,
    input  logic                        btn_down_i,
    input  logic                        btn_edit_i,
    input  logic [15:0]                 row_data_i,
    gol_run_controller_if.master        ctl,
    output logic [3:0]                  edit_row_o,
    output logic [1:0]                  state_o,
    output logic [31:0]                 generation_cnt_o,
    output logic [31:0]                 birth_cnt_o
);

    localparam int unsigned    TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]  TICK_ONE  = TW'(1);
    localparam logic [3:0]     ROW_LAST  = 4'(ROWS - 1);

    typedef enum logic [1:0] {
        S_EDIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t          state_q;
    logic            ret_run_q;     // 1: return to RUN after the generation, 0: PAUSE
    logic [TW-1:0]   tick_q;
    logic [3:0]      edit_row_q;
    logic            start_q;
    logic            we_q;
    logic [15:0]     wdata_q;
    logic [31:0]     gen_cnt_q;
    logic [31:0]     birth_cnt_q;

    logic            run_q, step_q, load_q, up_q, down_q, edit_q;
    logic            run_edge, step_edge, load_edge, up_edge, down_edge, edit_edge;
    logic            gen_done;
    logic [32:0]     birth_sum;

    // Previous button samples; reset high so a button held through reset is inert
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            run_q  <= 1'b1;
            step_q <= 1'b1;
            load_q <= 1'b1;
            up_q   <= 1'b1;
            down_q <= 1'b1;
            edit_q <= 1'b1;
        end else begin
            run_q  <= btn_run_i;
            step_q <= btn_step_i;
            load_q <= btn_load_i;
            up_q   <= btn_up_i;
            down_q <= btn_down_i;
            edit_q <= btn_edit_i;
        end
    end

    // Rising-edge detection and statistics arithmetic
    always_comb begin
        run_edge  = btn_run_i  & ~run_q;
        step_edge = btn_step_i & ~step_q;
        load_edge = btn_load_i & ~load_q;
        up_edge   = btn_up_i   & ~up_q;
        down_edge = btn_down_i & ~down_q;
        edit_edge = btn_edit_i & ~edit_q;
        gen_done  = (state_q == S_STEP) && ctl.eng_done_i;
        birth_sum = {1'b0, birth_cnt_q} + 33'(ctl.eng_births_i);
    end

    // Mode sequencer with registered start / row-write strobes
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            state_q    <= S_EDIT;
            ret_run_q  <= 1'b0;
            tick_q     <= '0;
            edit_row_q <= '0;
            start_q    <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            start_q <= 1'b0;
            we_q    <= 1'b0;
            unique case (state_q)
                S_EDIT: begin
                    if (run_edge) begin
                        state_q    <= S_RUN;
                        tick_q     <= '0;
                        edit_row_q <= '0;
                    end else if (step_edge) begin
                        if (!ctl.eng_busy_i) begin
                            start_q   <= 1'b1;
                            state_q   <= S_STEP;
                            ret_run_q <= 1'b0;
                        end
                    end else if (load_edge) begin
                        we_q    <= 1'b1;
                        wdata_q <= row_data_i;
                    end else if (up_edge && !down_edge) begin
                        if (edit_row_q != 4'd0)
                            edit_row_q <= edit_row_q - 4'd1;
                    end else if (down_edge && !up_edge) begin
                        if (edit_row_q != ROW_LAST)
                            edit_row_q <= edit_row_q + 4'd1;
                    end
                end
                S_RUN: begin
                    if (run_edge) begin
                        state_q <= S_PAUSE;
                    end else if (tick_q == TICK_LAST) begin
                        // terminal count is held while the engine is still busy
                        if (!ctl.eng_busy_i) begin
                            start_q   <= 1'b1;
                            tick_q    <= '0;
                            state_q   <= S_STEP;
                            ret_run_q <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_ONE;
                    end
                end
                S_PAUSE: begin
                    if (run_edge) begin
                        state_q <= S_RUN;
                        tick_q  <= '0;
                    end else if (step_edge) begin
                        if (!ctl.eng_busy_i) begin
                            start_q   <= 1'b1;
                            state_q   <= S_STEP;
                            ret_run_q <= 1'b0;
                        end
                    end else if (edit_edge) begin
                        state_q <= S_EDIT;
                    end
                end
                S_STEP: begin
                    // a run edge arriving with done still redirects this return
                    if (run_edge)
                        ret_run_q <= 1'b0;
                    if (ctl.eng_done_i)
                        state_q <= (ret_run_q && !run_edge) ? S_RUN : S_PAUSE;
                end
            endcase
        end
    end

    // Saturating generation and birth statistics
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            gen_cnt_q   <= '0;
            birth_cnt_q <= '0;
        end else if (gen_done) begin
            if (gen_cnt_q != '1)
                gen_cnt_q <= gen_cnt_q + 32'd1;
            birth_cnt_q <= birth_sum[32] ? '1 : birth_sum[31:0];
        end
    end

    assign ctl.eng_start_o = start_q;
    assign ctl.row_we_o    = we_q;
    assign ctl.row_sel_o   = edit_row_q;
    assign ctl.row_wdata_o = wdata_q;
    assign edit_row_o       = edit_row_q;
    assign state_o          = state_q;
    assign generation_cnt_o = gen_cnt_q;
    assign birth_cnt_o      = birth_cnt_q;

endmodule

// File: tb/tb_gol_run_controller.sv
// Bench for gol_run_controller: directed scenarios followed by randomized button
// and engine activity, all outputs compared every cycle against a mode-level model.
module tb_gol_run_controller;

    localparam int unsigned TICK_DIV = 4;
    localparam int MODE_EDIT  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_PAUSE = 2;
    localparam int MODE_STEP  = 3;
    localparam longint MAXV   = 64'hFFFF_FFFF;

    logic        ClkPort = 1'b0;
    logic        reset;
    logic [5:0]  btn;          // {edit, down, up, load, step, run}
    logic [15:0] row_data_i;
    logic [3:0]  edit_row_o;
    logic [1:0]  state_o;
    logic [31:0] generation_cnt_o;
    logic [31:0] birth_cnt_o;

    gol_run_controller_if ctl ();

    gol_run_controller #(.TICK_DIV(TICK_DIV), .ROWS(16)) dut (
        .ClkPort          (ClkPort),
        .reset            (reset),
        .btn_run_i        (btn[0]),
        .btn_step_i       (btn[1]),
        .btn_load_i       (btn[2]),
        .btn_up_i         (btn[3]),
        .btn_down_i       (btn[4]),
        .btn_edit_i       (btn[5]),
        .row_data_i       (row_data_i),
        .ctl              (ctl.master),
        .edit_row_o       (edit_row_o),
        .state_o          (state_o),
        .generation_cnt_o (generation_cnt_o),
        .birth_cnt_o      (birth_cnt_o)
    );

    always #5 ClkPort = ~ClkPort;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_starts = 0;

    // reference model
    int          m_mode, m_back, m_wait, m_row;
    longint      m_gen, m_births;
    bit          m_start, m_we;
    logic [15:0] m_wdata;
    logic [5:0]  last_btn;

    // engine model knobs
    int eng_phase = 0;
    int busy_len  = 2;
    int busy_rand = 0;
    int births_fix = 5;
    int hold_busy = 0;
    int spur_busy = 0;
    int spur_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_mode = MODE_EDIT; m_back = MODE_PAUSE; m_wait = 0; m_row = 0;
        m_gen = 0; m_births = 0; m_start = 0; m_we = 0; m_wdata = '0;
        last_btn = '1;
    endtask

    task automatic model_clock();
        logic [5:0] e;
        bit busy;
        e = btn & ~last_btn;
        last_btn = btn;
        busy = ctl.eng_busy_i;
        m_start = 0;
        m_we = 0;
        case (m_mode)
            MODE_EDIT: begin
                if (e[0]) begin
                    m_mode = MODE_RUN; m_wait = 0; m_row = 0;
                end else if (e[1]) begin
                    if (!busy) begin m_start = 1; m_mode = MODE_STEP; m_back = MODE_PAUSE; end
                end else if (e[2]) begin
                    m_we = 1; m_wdata = row_data_i;
                end else if (e[3] && !e[4]) begin
                    m_row = (m_row > 0) ? m_row - 1 : 0;
                end else if (e[4] && !e[3]) begin
                    m_row = (m_row < 15) ? m_row + 1 : 15;
                end
            end
            MODE_RUN: begin
                if (e[0]) m_mode = MODE_PAUSE;
                else if (m_wait == TICK_DIV - 1) begin
                    if (!busy) begin
                        m_start = 1; m_wait = 0; m_mode = MODE_STEP; m_back = MODE_RUN;
                    end
                end else m_wait++;
            end
            MODE_PAUSE: begin
                if (e[0]) begin m_mode = MODE_RUN; m_wait = 0; end
                else if (e[1]) begin
                    if (!busy) begin m_start = 1; m_mode = MODE_STEP; m_back = MODE_PAUSE; end
                end else if (e[5]) m_mode = MODE_EDIT;
            end
            default: begin
                if (e[0] && m_back == MODE_RUN) m_back = MODE_PAUSE;
                if (ctl.eng_done_i) begin
                    m_gen    = (m_gen + 1 > MAXV) ? MAXV : m_gen + 1;
                    m_births = (m_births + longint'(ctl.eng_births_i) > MAXV) ? MAXV
                               : m_births + longint'(ctl.eng_births_i);
                    m_mode = m_back;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state", 32'(state_o), 32'(m_mode));
        check("edit_row", 32'(edit_row_o), 32'(m_row));
        check("row_sel", 32'(ctl.row_sel_o), 32'(m_row));
        check("row_we", 32'(ctl.row_we_o), 32'(m_we));
        check("row_wdata", 32'(ctl.row_wdata_o), 32'(m_wdata));
        check("eng_start", 32'(ctl.eng_start_o), 32'(m_start));
        check("gen_cnt", generation_cnt_o, 32'(m_gen));
        check("birth_cnt", birth_cnt_o, 32'(m_births));
    endtask

    task automatic engine_drive();
        bit b, d;
        b = 0; d = 0;
        if (ctl.eng_start_o && eng_phase == 0)
            eng_phase = (busy_rand != 0 ? $urandom_range(1, 4) : busy_len) + 1;
        ctl.eng_births_i = 9'($urandom_range(0, 511));
        if (eng_phase > 1) b = 1;
        else if (eng_phase == 1) begin
            d = 1;
            ctl.eng_births_i = (births_fix >= 0) ? 9'(births_fix) : 9'($urandom_range(0, 256));
        end
        if (eng_phase > 0) eng_phase--;
        if (hold_busy > 0) begin b = 1; hold_busy--; end
        if (spur_busy != 0 && $urandom_range(0, 7) == 0) b = 1;
        if (spur_done != 0) begin d = 1; ctl.eng_births_i = 9'd100; spur_done = 0; end
        ctl.eng_busy_i = b;
        ctl.eng_done_i = d;
    endtask

    task automatic tick();
        @(posedge ClkPort);
        if (!reset) model_clock();
        #1;
        cyc++;
        if (ctl.eng_start_o) n_starts++;
        compare_all();
        engine_drive();
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        tick();
        btn[idx] = 1'b0;
        tick();
    endtask

    task automatic wait_state(input int want, input int limit, input string tag);
        for (int i = 0; i < limit && int'(state_o) != want; i++) tick();
        check(tag, 32'(state_o), 32'(want));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_entry, g0, s0;
        int st[3];
        int nst;
        logic [31:0] g_save, b_save;

        reset = 1'b1;
        btn = 6'b000001;
        row_data_i = '0;
        ctl.eng_busy_i = 1'b0;
        ctl.eng_done_i = 1'b0;
        ctl.eng_births_i = '0;
        model_reset();
        #12;
        compare_all();
        tick(); tick();
        reset = 1'b0;

        // run held through reset must not act
        repeat (4) tick();
        check("run_held_through_reset", 32'(state_o), MODE_EDIT);
        btn[0] = 1'b0; tick();
        btn[0] = 1'b1; tick();
        check("run_after_release", 32'(state_o), MODE_RUN);
        btn[0] = 1'b0; tick();
        press(0);
        wait_state(MODE_PAUSE, 4, "pause_from_run");
        press(5);
        wait_state(MODE_EDIT, 4, "edit_from_pause");

        // row editing
        repeat (3) press(4);
        check("row_after_down3", 32'(edit_row_o), 3);
        row_data_i = 16'hA5A5;
        btn[2] = 1'b1; tick();
        check("load_we", 32'(ctl.row_we_o), 1);
        check("load_sel", 32'(ctl.row_sel_o), 3);
        check("load_data", 32'(ctl.row_wdata_o), 32'hA5A5);
        btn[2] = 1'b0; tick();
        check("load_we_one_cycle", 32'(ctl.row_we_o), 0);
        repeat (5) press(3);
        check("row_after_up5", 32'(edit_row_o), 0);

        // RUN cadence with a 2-cycle engine
        births_fix = 5; busy_len = 2;
        btn[0] = 1'b1; tick(); c_entry = cyc; btn[0] = 1'b0;
        nst = 0;
        for (int i = 0; i < 80 && generation_cnt_o < 3; i++) begin
            tick();
            if (ctl.eng_start_o && nst < 3) begin st[nst] = cyc; nst++; end
        end
        check("launches_seen", 32'(nst), 3);
        check("first_launch_delay", 32'(st[0] - c_entry), TICK_DIV);
        check("launch_gap_1", 32'(st[1] - st[0]), 7);
        check("launch_gap_2", 32'(st[2] - st[1]), 7);
        check("gen_after_3", generation_cnt_o, 3);
        check("births_after_3", birth_cnt_o, 15);

        // run edge during STEP redirects the return to PAUSE
        wait_state(MODE_STEP, 10, "reach_step");
        press(0);
        wait_state(MODE_PAUSE, 20, "pause_after_step");
        g0 = int'(generation_cnt_o);
        s0 = n_starts;
        press(1);
        wait_state(MODE_PAUSE, 20, "pause_after_single");
        repeat (3) tick();
        check("single_step_gen", generation_cnt_o, 32'(g0 + 1));
        check("single_step_starts", 32'(n_starts - s0), 1);

        // tick expiry while the engine stays busy
        btn[0] = 1'b1; tick(); btn[0] = 1'b0;
        ctl.eng_busy_i = 1'b1; hold_busy = 9;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_start_while_busy", 32'(ctl.eng_start_o), 0);
        end
        tick();
        check("start_after_busy_drop", 32'(ctl.eng_start_o), 1);
        wait_state(MODE_RUN, 20, "run_after_hold");
        press(0);
        wait_state(MODE_PAUSE, 20, "pause_for_spurious");

        // spurious done in PAUSE
        g_save = generation_cnt_o; b_save = birth_cnt_o;
        spur_done = 1;
        repeat (3) tick();
        check("spurious_gen", generation_cnt_o, g_save);
        check("spurious_births", birth_cnt_o, b_save);
        check("spurious_state", 32'(state_o), MODE_PAUSE);

        // saturation
        force dut.gen_cnt_q = 32'hFFFF_FFFE;
        force dut.birth_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.gen_cnt_q;
        release dut.birth_cnt_q;
        m_gen = 64'hFFFF_FFFE; m_births = 64'hFFFF_FFFE;
        births_fix = 9;
        press(1);
        wait_state(MODE_PAUSE, 20, "pause_after_sat");
        tick();
        check("gen_saturated", generation_cnt_o, 32'hFFFF_FFFF);
        check("births_saturated", birth_cnt_o, 32'hFFFF_FFFF);
        births_fix = 256;
        press(1);
        wait_state(MODE_PAUSE, 20, "pause_after_sat2");
        tick();
        check("gen_still_saturated", generation_cnt_o, 32'hFFFF_FFFF);

        // asynchronous reset in the middle of STEP
        busy_len = 3;
        btn[1] = 1'b1; tick(); btn[1] = 1'b0;
        check("in_step_before_reset", 32'(state_o), MODE_STEP);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("late_done_ignored_gen", generation_cnt_o, 0);
        check("late_done_ignored_state", 32'(state_o), MODE_EDIT);

        // randomized activity
        births_fix = -1; busy_rand = 1; spur_busy = 1;
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, (b == 0) ? 23 : 5) == 0) btn[b] = ~btn[b];
            row_data_i = 16'($urandom);
            if ($urandom_range(0, 399) == 0) spur_done = 1;
            if ($urandom_range(0, 699) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
